// File: rtl/spi_read_scheduler_pkg.sv
// spi_read_scheduler_pkg
// Shared FSM state encodings and width helpers for the SPI read scheduler.
// No ports. Imported by spi_read_scheduler and rr_arbiter.
package spi_read_scheduler_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if (((value - 1) >> i) != 0) result = i + 1;
    end
    return result;
  endfunction

  // Width of an index into n items, never narrower than one bit.
  function automatic int idWidth(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_read_scheduler_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick: the first set pend bit strictly after
// the last owner, wrapping at NUM_REQ-1. The last owner itself is considered
// last, so a lone requester can be granted back-to-back.
// Ports:
//   pend_i        in  NUM_REQ  pending request bits
//   lastId_i      in  ID_W     owner of the previous grant
//   grantValid_o  out 1        some bit of pend_i is set
//   grantId_o     out ID_W     chosen requester (0 when grantValid_o=0)
module rr_arbiter
  import spi_read_scheduler_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = idWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pend_i,
  input  logic [ID_W-1:0]    lastId_i,
  output logic               grantValid_o,
  output logic [ID_W-1:0]    grantId_o
);

  // One spare bit so lastId + offset cannot overflow before the wrap.
  logic [ID_W:0] idx;

  // Walk offsets 1..NUM_REQ from the last owner; the first hit wins.
  always_comb begin
    grantValid_o = 1'b0;
    grantId_o    = '0;
    idx          = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, lastId_i} + (ID_W + 1)'(i);
      if (idx >= (ID_W + 1)'(NUM_REQ)) idx = idx - (ID_W + 1)'(NUM_REQ);
      if (!grantValid_o && pend_i[idx[ID_W-1:0]]) begin
        grantValid_o = 1'b1;
        grantId_o    = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_read_scheduler.sv
// spi_read_scheduler
// Shares one simpleSPI read engine between NUM_REQ requesters. Request pulses
// are latched into pend bits, granted round-robin, and each grant runs the
// engine's rd / d_ready handshake. The captured sample is returned with the
// owner id; hung handshakes are aborted after TIMEOUT cycles. Requester 0 can
// additionally be fed by a periodic auto-refresh tick.
// Ports:
//   SCLK        in  1        clock, posedge
//   rst_l       in  1        asynchronous active-low reset
//   auto_en     in  1        enable auto-refresh on requester 0
//   req         in  NUM_REQ  one-cycle request pulses
//   spi_rd      out 1        read strobe to engine, held until d_ready seen
//   spi_dready  in  1        engine data-ready
//   spi_d       in  DATA_W   engine sample, valid while spi_dready=1
//   rd_data     out DATA_W   last captured sample
//   rd_id       out ID_W     owner of rd_data (or of the aborted read)
//   done        out NUM_REQ  one-cycle completion pulse, bit = owner
//   err         out 1        one-cycle timeout-abort pulse
//   busy        out 1        FSM is not IDLE
module spi_read_scheduler
  import spi_read_scheduler_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int DATA_W         = 16,
  parameter  int REFRESH_PERIOD = 200000,
  parameter  int TIMEOUT        = 64,
  parameter  int GAP_CYCLES     = 4,
  localparam int ID_W           = idWidth(NUM_REQ)
) (
  input  logic               SCLK,
  input  logic               rst_l,
  input  logic               auto_en,
  input  logic [NUM_REQ-1:0] req,
  output logic               spi_rd,
  input  logic               spi_dready,
  input  logic [DATA_W-1:0]  spi_d,
  output logic [DATA_W-1:0]  rd_data,
  output logic [ID_W-1:0]    rd_id,
  output logic [NUM_REQ-1:0] done,
  output logic               err,
  output logic               busy
);

  localparam int TMR_W = clog2(max2(TIMEOUT, GAP_CYCLES) + 1);
  localparam int REF_W = idWidth(REFRESH_PERIOD);

  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(GAP_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_LAST     = REF_W'(REFRESH_PERIOD - 1);

  logic [1:0]         state_q,   state_d;
  logic [TMR_W-1:0]   timer_q,   timer_d;
  logic [ID_W-1:0]    owner_q,   owner_d;
  logic [NUM_REQ-1:0] pend_q,    pend_d;
  logic [REF_W-1:0]   refCnt_q,  refCnt_d;
  logic               spiRd_q,   spiRd_d;
  logic [DATA_W-1:0]  rdData_q,  rdData_d;
  logic [ID_W-1:0]    rdId_q,    rdId_d;
  logic [NUM_REQ-1:0] done_q,    done_d;
  logic               err_q,     err_d;

  logic               refreshTick;
  logic [NUM_REQ-1:0] pendClr;
  logic               grantValid;
  logic [ID_W-1:0]    grantId;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .pend_i       (pend_q),
    .lastId_i     (owner_q),
    .grantValid_o (grantValid),
    .grantId_o    (grantId)
  );

  // Refresh counter runs only while enabled; disabling parks it at 0 so a
  // later enable always waits a full period before the first tick.
  assign refreshTick = auto_en && (refCnt_q == REF_LAST);

  always_comb begin
    refCnt_d = refCnt_q + REF_W'(1);
    if (!auto_en || refreshTick) refCnt_d = '0;
  end

  // Set beats clear: a request landing on its own completion cycle stays pending.
  assign pend_d = (pend_q & ~pendClr) | req | NUM_REQ'(refreshTick);

  // Transaction FSM. The timer restarts on every state change; IDLE holds it at 0.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TMR_W'(1);
    owner_d  = owner_q;
    spiRd_d  = spiRd_q;
    rdData_d = rdData_q;
    rdId_d   = rdId_q;
    done_d   = '0;
    err_d    = 1'b0;
    pendClr  = '0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (grantValid) begin
          owner_d = grantId;
          spiRd_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (spi_dready) begin
          rdData_d = spi_d;
          rdId_d   = owner_q;
          spiRd_d  = 1'b0;
          timer_d  = '0;
          state_d  = ST_RELEASE;
        end else if (timer_q == TIMEOUT_LAST) begin
          spiRd_d          = 1'b0;
          err_d            = 1'b1;
          rdId_d           = owner_q;
          pendClr[owner_q] = 1'b1;
          timer_d          = '0;
          state_d          = ST_GAP;
        end
      end
      ST_RELEASE: begin
        if (!spi_dready) begin
          done_d[owner_q]  = 1'b1;
          pendClr[owner_q] = 1'b1;
          timer_d          = '0;
          state_d          = ST_GAP;
        end else if (timer_q == TIMEOUT_LAST) begin
          err_d            = 1'b1;
          rdId_d           = owner_q;
          pendClr[owner_q] = 1'b1;
          timer_d          = '0;
          state_d          = ST_GAP;
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        timer_d = '0;
        spiRd_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Owner resets to the top index so the first search after reset starts at bit 0.
  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      owner_q  <= ID_W'(NUM_REQ - 1);
      pend_q   <= '0;
      refCnt_q <= '0;
      spiRd_q  <= 1'b0;
      rdData_q <= '0;
      rdId_q   <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      owner_q  <= owner_d;
      pend_q   <= pend_d;
      refCnt_q <= refCnt_d;
      spiRd_q  <= spiRd_d;
      rdData_q <= rdData_d;
      rdId_q   <= rdId_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign spi_rd  = spiRd_q;
  assign rd_data = rdData_q;
  assign rd_id   = rdId_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_read_scheduler.sv
// tb_spi_read_scheduler
// Scoreboard bench for spi_read_scheduler. Stimulus pushes the expected
// done/err events into expQ; a negedge monitor pops and compares whenever the
// DUT pulses done or err. A small engine model answers spi_rd.
module tb_spi_read_scheduler;

  localparam int NUM_REQ        = 2;
  localparam int DATA_W         = 16;
  localparam int REFRESH_PERIOD = 10;
  localparam int TIMEOUT        = 64;
  localparam int GAP_CYCLES     = 4;

  typedef struct {
    bit          isErr;
    logic [0:0]  id;
    logic [15:0] data;
  } expT;

  logic              SCLK;
  logic              rst_l;
  logic              auto_en;
  logic [1:0]        req;
  logic              spi_rd;
  logic              spi_dready;
  logic [15:0]       spi_d;
  logic [15:0]       rd_data;
  logic [0:0]        rd_id;
  logic [1:0]        done;
  logic              err;
  logic              busy;

  int          checksRun    = 0;
  int          checksPassed = 0;
  expT         expQ[$];
  logic [15:0] engDataQ[$];
  bit          engHang  = 1'b0;
  int          engDelay = 5;
  int          cyc      = 0;
  int          rdRises  = 0;
  int          rdHigh   = 0;
  bit          rdPrev   = 1'b0;
  int          rdRiseQ[$];
  int          doneCycQ[$];

  spi_read_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .DATA_W         (DATA_W),
    .REFRESH_PERIOD (REFRESH_PERIOD),
    .TIMEOUT        (TIMEOUT),
    .GAP_CYCLES     (GAP_CYCLES)
  ) dut (
    .SCLK       (SCLK),
    .rst_l      (rst_l),
    .auto_en    (auto_en),
    .req        (req),
    .spi_rd     (spi_rd),
    .spi_dready (spi_dready),
    .spi_d      (spi_d),
    .rd_data    (rd_data),
    .rd_id      (rd_id),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksRun++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic pushExp(input bit isErr, input logic [0:0] id, input logic [15:0] data);
    expT e;
    e.isErr = isErr;
    e.id    = id;
    e.data  = data;
    expQ.push_back(e);
  endtask

  // Drives req for exactly one sampling edge; returns just after that edge.
  task automatic applyStimulus(input logic [1:0] r);
    @(posedge SCLK); #1;
    req = r;
    @(posedge SCLK); #1;
    req = 2'b00;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((expQ.size() != 0 || busy) && n < budget) begin
      @(posedge SCLK); #1;
      n++;
    end
    checkOutput({name, "_drained"}, expQ.size(), 0);
    checkOutput({name, "_idle"}, 32'(busy), 0);
  endtask

  task automatic doReset();
    @(negedge SCLK);
    rst_l = 1'b0;
    repeat (2) @(negedge SCLK);
    rst_l = 1'b1;
    @(posedge SCLK); #1;
  endtask

  // Engine model: after seeing spi_rd, waits engDelay edges, presents the next
  // queued sample with d_ready, and drops d_ready once spi_rd has fallen.
  initial begin : engine
    int n;
    spi_dready = 1'b0;
    spi_d      = '0;
    forever begin
      @(posedge SCLK); #1;
      if (rst_l && spi_rd && !engHang) begin
        repeat (engDelay) @(posedge SCLK);
        #1;
        spi_d      = (engDataQ.size() != 0) ? engDataQ.pop_front() : 16'h0000;
        spi_dready = 1'b1;
        n = 0;
        while (spi_rd && n < 200) begin
          @(posedge SCLK); #1;
          n++;
        end
        spi_dready = 1'b0;
      end
    end
  end

  // Monitor: tracks spi_rd activity and scores every done/err pulse against expQ.
  always @(negedge SCLK) begin : monitor
    expT e;
    int  expDone;
    cyc++;
    if (!rst_l) begin
      rdPrev = 1'b0;
    end else begin
      if (spi_rd) rdHigh++;
      if (spi_rd && !rdPrev) begin
        rdRises++;
        rdRiseQ.push_back(cyc);
      end
      rdPrev = spi_rd;
      if (done != 2'b00) doneCycQ.push_back(cyc);
      if (done != 2'b00 || err) begin
        checkOutput("done_err_exclusive", 32'(done != 2'b00 && err), 0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event", 32'({done, err}), 0);
        end else begin
          e = expQ.pop_front();
          expDone = e.isErr ? 0 : (e.id == 1'b1 ? 2 : 1);
          checkOutput("sb_done", 32'(done), expDone);
          checkOutput("sb_err", 32'(err), 32'(e.isErr));
          checkOutput("sb_id", 32'(rd_id), 32'(e.id));
          if (!e.isErr) checkOutput("sb_data", 32'(rd_data), 32'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    int  n;
    int  enableCyc;
    bit  seenHigh;
    rst_l   = 1'b0;
    auto_en = 1'b0;
    req     = 2'b00;

    // Reset values
    repeat (3) @(posedge SCLK); #1;
    checkOutput("rst_spi_rd", 32'(spi_rd), 0);
    checkOutput("rst_rd_data", 32'(rd_data), 0);
    checkOutput("rst_rd_id", 32'(rd_id), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    @(negedge SCLK);
    rst_l = 1'b1;
    @(posedge SCLK); #1;

    // T1 single read with 2-cycle grant latency
    $display("[TB] T1 single read");
    engDelay = 5;
    engDataQ.push_back(16'hA5C3);
    pushExp(1'b0, 1'b0, 16'hA5C3);
    rdRises = 0;
    applyStimulus(2'b01);
    checkOutput("t1_rd_not_early", 32'(spi_rd), 0);
    @(posedge SCLK); #1;
    checkOutput("t1_rd_latency", 32'(spi_rd), 1);
    checkOutput("t1_busy", 32'(busy), 1);
    waitDrain("t1", 300);
    checkOutput("t1_rd_count", rdRises, 1);

    // T2 contention after reset: 0 then 1, GAP + arbitration between
    $display("[TB] T2 contention");
    doReset();
    engDelay = 3;
    rdRises  = 0;
    rdRiseQ.delete();
    doneCycQ.delete();
    engDataQ.push_back(16'h1111);
    engDataQ.push_back(16'h2222);
    pushExp(1'b0, 1'b0, 16'h1111);
    pushExp(1'b0, 1'b1, 16'h2222);
    applyStimulus(2'b11);
    waitDrain("t2", 300);
    checkOutput("t2_rd_count", rdRises, 2);
    checkOutput("t2_gap", (rdRiseQ.size() > 1 && doneCycQ.size() > 0) ? rdRiseQ[1] - doneCycQ[0] : -1,
                GAP_CYCLES + 1);

    // T3 timeout on requester 1: rd held TIMEOUT cycles, err, no retry
    $display("[TB] T3 timeout");
    engHang = 1'b1;
    rdRises = 0;
    rdHigh  = 0;
    pushExp(1'b1, 1'b1, 16'h0000);
    applyStimulus(2'b10);
    waitDrain("t3", 200);
    checkOutput("t3_rd_high_cycles", rdHigh, TIMEOUT);
    checkOutput("t3_rd_data_held", 32'(rd_data), 32'h2222);
    repeat (20) @(posedge SCLK); #1;
    checkOutput("t3_no_retry", rdRises, 1);
    engHang = 1'b0;

    // T4 auto-refresh: ticks 10 cycles apart, stop, then restart from 0
    $display("[TB] T4 auto-refresh");
    engDelay = 1;
    rdRises  = 0;
    rdRiseQ.delete();
    engDataQ.push_back(16'hC001);
    engDataQ.push_back(16'hC002);
    engDataQ.push_back(16'hC003);
    pushExp(1'b0, 1'b0, 16'hC001);
    pushExp(1'b0, 1'b0, 16'hC002);
    pushExp(1'b0, 1'b0, 16'hC003);
    @(posedge SCLK); #1;
    auto_en   = 1'b1;
    enableCyc = cyc;
    repeat (35) @(posedge SCLK); #1;
    auto_en = 1'b0;
    repeat (40) @(posedge SCLK); #1;
    checkOutput("t4_grant_count", rdRises, 3);
    checkOutput("t4_first_tick", (rdRiseQ.size() > 0) ? rdRiseQ[0] - enableCyc : -1, 12);
    checkOutput("t4_period_a", (rdRiseQ.size() > 1) ? rdRiseQ[1] - rdRiseQ[0] : -1, REFRESH_PERIOD);
    checkOutput("t4_period_b", (rdRiseQ.size() > 2) ? rdRiseQ[2] - rdRiseQ[1] : -1, REFRESH_PERIOD);
    engDataQ.push_back(16'hC004);
    pushExp(1'b0, 1'b0, 16'hC004);
    auto_en   = 1'b1;
    enableCyc = cyc;
    n = 0;
    while (rdRiseQ.size() < 4 && n < 30) begin
      @(posedge SCLK); #1;
      n++;
    end
    auto_en = 1'b0;
    checkOutput("t4_count_restart", (rdRiseQ.size() > 3) ? rdRiseQ[3] - enableCyc : -1, 12);
    waitDrain("t4", 100);

    // T5 re-request of 1 on the cycle its completion clears pend
    $display("[TB] T5 re-request");
    engDelay = 2;
    rdRises  = 0;
    engDataQ.push_back(16'hD501);
    engDataQ.push_back(16'hD502);
    pushExp(1'b0, 1'b1, 16'hD501);
    pushExp(1'b0, 1'b1, 16'hD502);
    applyStimulus(2'b10);
    seenHigh = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge SCLK); #1;
      n++;
      if (spi_rd) seenHigh = 1'b1;
      else if (seenHigh) break;
    end
    req = 2'b10;
    @(posedge SCLK); #1;
    req = 2'b00;
    waitDrain("t5", 300);
    checkOutput("t5_rd_count", rdRises, 2);

    // T6 async reset while spi_rd is high
    $display("[TB] T6 reset mid-REQ");
    engHang = 1'b1;
    applyStimulus(2'b01);
    n = 0;
    while (!spi_rd && n < 20) begin
      @(posedge SCLK); #1;
      n++;
    end
    repeat (3) @(posedge SCLK);
    #1;
    checkOutput("t6_pre_rd", 32'(spi_rd), 1);
    #2;
    rst_l = 1'b0;
    #1;
    checkOutput("t6_spi_rd", 32'(spi_rd), 0);
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_rd_data", 32'(rd_data), 0);
    checkOutput("t6_rd_id", 32'(rd_id), 0);
    checkOutput("t6_done", 32'(done), 0);
    checkOutput("t6_err", 32'(err), 0);
    @(negedge SCLK);
    @(negedge SCLK);
    rst_l = 1'b1;
    @(posedge SCLK); #1;
    engHang = 1'b0;
    rdRises = 0;
    repeat (30) @(posedge SCLK); #1;
    checkOutput("t6_no_pending", rdRises, 0);
    checkOutput("t6_idle", 32'(busy), 0);
    checkOutput("t6_queue_empty", expQ.size(), 0);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
